// File: rtl/bilateral_norm_div_pkg.sv
// Shared constants and FSM state type for the bilateral filter datapath.
package bilateral_pkg;

  localparam int unsigned NUM_W   = 29;
  localparam int unsigned DEN_W   = 21;
  localparam int unsigned PIX_W   = 8;
  localparam int unsigned FRAC    = 1;
  localparam int unsigned QB      = PIX_W + FRAC;
  localparam int unsigned PIX_MAX = (1 << PIX_W) - 1;

  typedef enum logic [1:0] {
    IDLE,
    DIV,
    DONE
  } state_t;

endpackage

// File: rtl/bilateral_norm_div_if.sv
// Operand/result handshake bundle for the normalisation divider.
interface bilateral_norm_div_if;

  logic                            in_valid;
  logic                            in_ready;
  logic [bilateral_pkg::NUM_W-1:0] in_num;
  logic [bilateral_pkg::DEN_W-1:0] in_den;
  logic                            out_valid;
  logic                            out_ready;
  logic [bilateral_pkg::PIX_W-1:0] out_pix;
  logic                            out_sat;
  logic                            out_dz;

  modport master (
    output in_valid, in_num, in_den, out_ready,
    input  in_ready, out_valid, out_pix, out_sat, out_dz
  );

  modport slave (
    input  in_valid, in_num, in_den, out_ready,
    output in_ready, out_valid, out_pix, out_sat, out_dz
  );

endinterface

// File: rtl/bilateral_norm_div_core.sv
// Iterative restoring divider: one quotient bit per cycle, MSB first.
module restoring_div_core #(
  parameter int unsigned DVD_W = 30,
  parameter int unsigned DEN_W = 21,
  parameter int unsigned QB    = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic [DVD_W-1:0] i_dividend,
  input  logic [DEN_W-1:0] i_divisor,
  output logic             o_busy,
  output logic             o_done,
  output logic [QB-1:0]    o_quot
);

  localparam int unsigned CNT_W = $clog2(QB + 1);

  logic [DEN_W-1:0] r_rem;
  logic [DEN_W-1:0] r_den;
  logic [QB-1:0]    r_low;
  logic [QB-1:0]    r_quot;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_done;

  // Caller guarantees dividend >> QB < divisor, so the remainder fits DEN_W
  // bits and the shifted trial value fits DEN_W+1.
  logic [DEN_W:0]   w_trial;
  logic             w_ge;
  logic [DEN_W-1:0] w_rem_nxt;

  always_comb begin
    w_trial   = {r_rem, r_low[QB-1]};
    w_ge      = (w_trial >= {1'b0, r_den});
    w_rem_nxt = w_ge ? DEN_W'(w_trial - {1'b0, r_den}) : w_trial[DEN_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rem  <= '0;
      r_den  <= '0;
      r_low  <= '0;
      r_quot <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_start && !r_busy) begin
        r_rem  <= DEN_W'(i_dividend[DVD_W-1:QB]);
        r_low  <= i_dividend[QB-1:0];
        r_den  <= i_divisor;
        r_quot <= '0;
        r_cnt  <= CNT_W'(QB);
        r_busy <= 1'b1;
      end else if (r_busy) begin
        r_rem  <= w_rem_nxt;
        r_low  <= {r_low[QB-2:0], 1'b0};
        r_quot <= {r_quot[QB-2:0], w_ge};
        r_cnt  <= r_cnt - CNT_W'(1);
        if (r_cnt == CNT_W'(1)) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_quot = r_quot;

endmodule

// File: rtl/bilateral_norm_div.sv
// Normalises sum(w*I)/sum(w) to a rounded, saturated 8-bit pixel.
module bilateral_norm_div
  import bilateral_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  bilateral_norm_div_if.slave  bus
);

  state_t r_state, w_next;

  logic [PIX_W-1:0] r_pix, w_pix;
  logic             r_sat, w_sat;
  logic             r_dz,  w_dz;
  logic             r_dz_pend;
  logic             r_ovf_pend;

  logic             w_accept;
  logic             w_in_dz;
  logic             w_in_ovf;
  logic             w_start;
  logic             w_busy;
  logic             w_done;
  logic [QB-1:0]    w_quot;
  logic [QB:0]      w_round;

  restoring_div_core #(
    .DVD_W (NUM_W + FRAC),
    .DEN_W (DEN_W),
    .QB    (QB)
  ) u_core (
    .clk        (clk),
    .rst        (rst),
    .i_start    (w_start),
    .i_dividend ({bus.in_num, {FRAC{1'b0}}}),
    .i_divisor  (bus.in_den),
    .o_busy     (w_busy),
    .o_done     (w_done),
    .o_quot     (w_quot)
  );

  assign w_accept = bus.in_valid && (r_state == IDLE);
  assign w_in_dz  = (bus.in_den == '0);
  assign w_in_ovf = ({1'b0, bus.in_num} >= {1'b0, bus.in_den, {PIX_W{1'b0}}});
  assign w_round  = ({1'b0, w_quot} + (QB+1)'(1)) >> 1;

  // Bypass results are decided at acceptance but presented one cycle later,
  // so every path leaves DIV through the same DONE transition.
  always_comb begin
    w_next  = r_state;
    w_pix   = r_pix;
    w_sat   = r_sat;
    w_dz    = r_dz;
    w_start = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_next  = DIV;
          w_start = !w_in_dz && !w_in_ovf && !w_busy;
        end
      end
      DIV: begin
        if (r_dz_pend) begin
          w_next = DONE;
          w_pix  = '0;
          w_sat  = 1'b0;
          w_dz   = 1'b1;
        end else if (r_ovf_pend) begin
          w_next = DONE;
          w_pix  = PIX_W'(PIX_MAX);
          w_sat  = 1'b1;
          w_dz   = 1'b0;
        end else if (w_done) begin
          w_next = DONE;
          w_dz   = 1'b0;
          if (w_round > (QB+1)'(PIX_MAX)) begin
            w_pix = PIX_W'(PIX_MAX);
            w_sat = 1'b1;
          end else begin
            w_pix = w_round[PIX_W-1:0];
            w_sat = 1'b0;
          end
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pix      <= '0;
      r_sat      <= 1'b0;
      r_dz       <= 1'b0;
      r_dz_pend  <= 1'b0;
      r_ovf_pend <= 1'b0;
    end else begin
      r_pix <= w_pix;
      r_sat <= w_sat;
      r_dz  <= w_dz;
      if (w_accept) begin
        r_dz_pend  <= w_in_dz;
        r_ovf_pend <= w_in_ovf;
      end
    end
  end

  assign bus.in_ready  = (r_state == IDLE);
  assign bus.out_valid = (r_state == DONE);
  assign bus.out_pix   = r_pix;
  assign bus.out_sat   = r_sat;
  assign bus.out_dz    = r_dz;

endmodule

// File: tb/tb_bilateral_norm_div.sv
// Directed and random operand pairs checked against a rounding-division model.
module tb_bilateral_norm_div;
  import bilateral_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bilateral_norm_div_if bus ();

  bilateral_norm_div dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // round(num/den) half-up = floor((2*num + den) / (2*den))
  function automatic void model(input longint unsigned num, input longint unsigned den,
                                output logic [7:0] pix, output logic sat,
                                output logic dz, output int unsigned lat);
    longint unsigned r;
    pix = 8'd0; sat = 1'b0; dz = 1'b0; lat = 10;
    if (den == 0) begin
      dz = 1'b1; lat = 1;
    end else if (num >= den * 256) begin
      pix = 8'd255; sat = 1'b1; lat = 1;
    end else begin
      r = (2 * num + den) / (2 * den);
      if (r > 255) begin
        pix = 8'd255; sat = 1'b1;
      end else begin
        pix = 8'(r);
      end
    end
  endfunction

  task automatic wait_ready(input string tag);
    int unsigned n = 0;
    while (!bus.in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "/in_ready"}, 32'(bus.in_ready), 32'd1);
  endtask

  task automatic run_op(input logic [NUM_W-1:0] num, input logic [DEN_W-1:0] den,
                        input int unsigned stall, input string tag);
    logic [7:0]  e_pix;
    logic        e_sat, e_dz;
    int unsigned e_lat;
    int unsigned lat = 0;
    model(longint'(num), longint'(den), e_pix, e_sat, e_dz, e_lat);
    wait_ready(tag);
    bus.in_valid  = 1'b1;
    bus.in_num    = num;
    bus.in_den    = den;
    bus.out_ready = (stall == 0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_num   = NUM_W'($urandom);
    bus.in_den   = DEN_W'($urandom);
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "/latency"}, 32'(lat), 32'(e_lat));
    chk({tag, "/pix"}, 32'(bus.out_pix), 32'(e_pix));
    chk({tag, "/sat"}, 32'(bus.out_sat), 32'(e_sat));
    chk({tag, "/dz"}, 32'(bus.out_dz), 32'(e_dz));
    chk({tag, "/busy_ready"}, 32'(bus.in_ready), 32'd0);
    for (int unsigned i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      chk({tag, "/hold_valid"}, 32'(bus.out_valid), 32'd1);
      chk({tag, "/hold_pix"}, 32'(bus.out_pix), 32'(e_pix));
      chk({tag, "/hold_ready"}, 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk({tag, "/post_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "/post_ready"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    logic [DEN_W-1:0] rd;
    logic [NUM_W-1:0] rn;
    longint unsigned  lim;

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_num    = '0;
    bus.in_den    = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst/in_ready",  32'(bus.in_ready),  32'd1);
    chk("rst/out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst/out_pix",   32'(bus.out_pix),   32'd0);
    chk("rst/out_sat",   32'(bus.out_sat),   32'd0);
    chk("rst/out_dz",    32'(bus.out_dz),    32'd0);
    rst = 1'b0;

    run_op(29'd1000, 21'd10, 0, "basic");
    run_op(29'd15,   21'd10, 0, "round15");
    run_op(29'd14,   21'd10, 0, "round14");
    run_op(29'd25,   21'd10, 0, "round25");
    run_op(29'd500,  21'd0,  0, "divzero");
    run_op(29'd3000, 21'd10, 0, "sat_pre");
    run_op(29'd2555, 21'd10, 0, "sat_round");
    run_op(29'd2559, 21'd10, 0, "below_pre");
    run_op(29'd2560, 21'd10, 0, "at_pre");
    run_op(29'd0,    21'd1,  0, "zero_num");
    run_op(29'd1000, 21'd10, 5, "backpressure");
    run_op(29'd77,   21'd3,  0, "back2back");

    // Abort mid-division; the in-flight result must never appear.
    wait_ready("abort");
    bus.in_valid = 1'b1;
    bus.in_num   = 29'd1000;
    bus.in_den   = 21'd7;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort/in_ready",  32'(bus.in_ready),  32'd1);
    chk("abort/out_valid", 32'(bus.out_valid), 32'd0);
    repeat (12) @(posedge clk);
    #1;
    chk("abort/no_result", 32'(bus.out_valid), 32'd0);
    run_op(29'd2040, 21'd8, 0, "after_abort");

    for (int unsigned k = 0; k < 40; k++) begin
      if ($urandom_range(0, 7) == 0) begin
        rd = '0;
      end else if ($urandom_range(0, 1) == 0) begin
        rd = DEN_W'($urandom_range(1, 300));
      end else begin
        rd = DEN_W'($urandom);
      end
      lim = longint'(rd) * 264 + 1;
      rn  = NUM_W'(longint'($urandom) % lim);
      run_op(rn, rd, $urandom_range(0, 2), "random");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/bilateral_norm_div.md
Name: bilateral_norm_div

Overview:
- Normalisation stage placed directly downstream of the 121-tap weight-sum adder tree.
- Takes the weighted pixel sum sum(w*I) and the weight sum sum(w) (21-bit accumulated result) for one 11x11 window.
- Computes the filtered pixel as round(num/den) with an iterative restoring divider.
- Returns an 8-bit pixel with saturation and divide-by-zero handling; valid/ready handshakes on both sides.

Parameters:
- NUM_W, 29, numerator width (8-bit pixel x 14-bit weight x 121 taps).
- DEN_W, 21, denominator width; matches the weight-sum output.
- PIX_W, 8, output pixel width.
- FRAC, 1, extra quotient bits used for rounding; only 1 is supported.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  num/den are valid.
- in_ready  out  1  block can accept an operand pair.
- in_num  in  NUM_W  weighted pixel sum (unsigned).
- in_den  in  DEN_W  weight sum (unsigned).
- out_valid  out  1  result is valid.
- out_ready  in  1  downstream accepts the result.
- out_pix  out  PIX_W  rounded, saturated quotient.
- out_sat  out  1  result was clamped to 2^PIX_W-1.
- out_dz  out  1  den was 0; out_pix forced to 0.

Behaviour:
- Reset and synchronicity: one clock (clk); reset is synchronous and active-high (rst).
- Reset values: state=IDLE; in_ready=1; out_valid=0; out_pix=0; out_sat=0; out_dz=0; internal registers cleared. Reset mid-division aborts the operation and drops the result.
- FSM states: IDLE, DIV, DONE.
- in_ready=1 only in IDLE. Acceptance is in_valid&&in_ready at a rising edge; num and den are registered on that edge.
- At acceptance:
  - den==0 -> DONE next cycle with out_pix=0, out_dz=1, out_sat=0.
  - num >= den<<PIX_W -> DONE next cycle with out_pix=255, out_sat=1, out_dz=0.
  - Otherwise -> DIV with iteration count = PIX_W+FRAC = 9.
- DIV:
  - Each cycle produces one quotient bit, MSB first.
  - Compare the partial remainder against den; subtract if greater or equal; shift the bit into q (9 bits).
  - After the 9th iteration go to DONE.
  - The mathematical result is q = floor(2*num/den), with 0 <= q <= 511.
- Rounding:
  - r = (q+1)>>1, i.e. round half up.
  - If r == 256: out_pix=255, out_sat=1.
  - Otherwise out_pix=r[7:0], out_sat=0.
- Latency:
  - Normal path: out_valid rises 10 edges after the acceptance edge (1 load + 9 iterations).
  - dz/overflow path: out_valid rises 1 edge after acceptance.
- DONE:
  - out_valid=1; out_pix, out_sat and out_dz are held stable until out_ready.
  - On out_valid&&out_ready -> IDLE and out_valid=0 next cycle.
- No pipelining: one operation in flight. The next acceptance is possible the cycle after the output handshake, since in_ready is registered from state.
- Simultaneous rst and handshake: rst wins.
- in_num/in_den are ignored when not accepted.
- out_pix retains its last value while out_valid=0 (not cleared); the bench must check it only when out_valid=1.
- Arithmetic:
  - All unsigned.
  - Partial remainder is DEN_W+1 bits so the subtract compare cannot overflow.
  - No truncation of num beyond the overflow pre-check.

Decomposition:
- Shared package bilateral_pkg holds:
  - NUM_W, DEN_W, PIX_W constants, shared with the weight-sum adder tree and the pixel-weight accumulator.
  - FSM state enum (IDLE/DIV/DONE).
  - PIX_MAX = 255.
- One natural sub-module: restoring_div_core, an iterative unsigned divider with start/busy/done, parameterised on quotient bits.
- bilateral_norm_div wraps restoring_div_core with the pre-checks, rounding/saturation, and the valid/ready handshake.

Test Plan:
- num=1000, den=10, out_ready=1 -> out_pix=100, sat=0, dz=0; out_valid 10 cycles after acceptance.
- Rounding: num=15, den=10 -> 2; num=14, den=10 -> 1; num=25, den=10 -> 3.
- Divide by zero: num=500, den=0 -> out_pix=0, dz=1, out_valid 1 cycle after acceptance.
- Saturation: num=3000, den=10 (pre-check) -> 255, sat=1, 1-cycle latency; num=2555, den=10 (rounds to 256) -> 255, sat=1, 10-cycle latency.
- Backpressure: out_ready=0 for 5 cycles after out_valid -> out_pix/out_valid held and in_ready=0; on release, in_ready=1 the next cycle and back-to-back ops succeed.
- Reset mid-DIV: assert rst at iteration 4 -> next cycle in_ready=1, out_valid=0; new op num=2040, den=8 -> 255, sat=0.
